// File: rtl/mux_tree_serializer.sv
// Parallel-in, serial-out sequencer for a 2**SEL_W-to-1 mux tree.
// It captures a word via valid/ready and presents it on mux_data_o. It then steps
// mux_sel_o through every input, LSB first, and forwards the tree's combinational
// output (mux_in_i) as a flow-controlled serial stream.
// Optional feature: define SERIALIZER_PARITY_EN to append an even-parity beat
// after the data beats. With the feature, ser_last_o marks the parity beat
// instead of data beat WIDTH-1.
// WIDTH must equal 2**SEL_W.
module mux_tree_serializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] mux_data_o,
  output logic [SEL_W-1:0] mux_sel_o,
  input  logic             mux_in_i,
  output logic             ser_bit_o,
  output logic             ser_valid_o,
  input  logic             ser_ready_i,
  output logic             ser_last_o
);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign mux_data_o = data_q;
  assign mux_sel_o  = sel_q;

  // Next-state and handshake outputs; ser_bit_o passes mux_in_i straight through.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    sel_d        = sel_q;
`ifdef SERIALIZER_PARITY_EN
    parity_d     = parity_q;
`endif
    load_ready_o = 1'b0;
    ser_valid_o  = 1'b0;
    ser_bit_o    = 1'b0;
    ser_last_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready_o = 1'b1;
        if (load_valid_i) begin
          data_d   = din_i;
          sel_d    = '0;
`ifdef SERIALIZER_PARITY_EN
          parity_d = ^din_i;
`endif
          state_d  = StShift;
        end
      end
      StShift: begin
        ser_valid_o = 1'b1;
        ser_bit_o   = mux_in_i;
`ifndef SERIALIZER_PARITY_EN
        ser_last_o  = (sel_q == LastSel);
`endif
        if (ser_ready_i) begin
          if (sel_q == LastSel) begin
            // Select parks at 0 rather than wrapping past the last input.
            sel_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
`endif
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      StParity: begin
        ser_valid_o = 1'b1;
        ser_bit_o   = parity_q;
        ser_last_o  = 1'b1;
        if (ser_ready_i) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset wins over any handshake in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      data_q   <= '0;
      sel_q    <= '0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_tree_serializer.sv
// Directed testbench for mux_tree_serializer.
// The bench models the downstream mux tree as mux_data[mux_sel].
module tb_mux_tree_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] din;
  logic [15:0] mux_data;
  logic [3:0]  mux_sel;
  logic        mux_in;
  logic        ser_bit;
  logic        ser_valid;
  logic        ser_ready;
  logic        ser_last;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef SERIALIZER_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  always #5 clk = ~clk;

  // Ideal 16-to-1 mux tree on the return path.
  assign mux_in = mux_data[mux_sel];

  mux_tree_serializer #(
    .WIDTH(16),
    .SEL_W(4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_valid_i(load_valid),
    .load_ready_o(load_ready),
    .din_i       (din),
    .mux_data_o  (mux_data),
    .mux_sel_o   (mux_sel),
    .mux_in_i    (mux_in),
    .ser_bit_o   (ser_bit),
    .ser_valid_o (ser_valid),
    .ser_ready_i (ser_ready),
    .ser_last_o  (ser_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a single cycle; the caller ensures the DUT is idle.
  task automatic load_word(input logic [15:0] w);
    din        = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; din = 16'h0; ser_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({load_ready, ser_valid, ser_last} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_flags: ready/valid/last=%b, want 100", {load_ready, ser_valid, ser_last});
    end
    n_cmp++;
    if (mux_data !== 16'h0 || mux_sel !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_regs: data=%h sel=%h, want 0000 0", mux_data, mux_sel);
    end
  endtask

  task automatic test_basic();
    logic [15:0] seq;
    // Expected beats for A5C3, written beat 0 first.
    seq = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ser_ready = 1'b1;
    load_word(16'hA5C3);
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (ser_valid !== 1'b1 || ser_bit !== seq[15-k] ||
          ser_last !== (!ParEn && k == 15)) begin
        n_bad++;
        $display("FAIL basic_beat%0d: valid=%b bit=%b last=%b, want 1 %b %b", k, ser_valid,
                 ser_bit, ser_last, seq[15-k], (!ParEn && k == 15));
      end
      tick();
    end
`ifdef SERIALIZER_PARITY_EN
    n_cmp++;
    if (ser_valid !== 1'b1 || ser_bit !== 1'b0 || ser_last !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_parity: valid=%b bit=%b last=%b, want 1 0 1", ser_valid, ser_bit,
               ser_last);
    end
    tick();
`endif
    n_cmp++;
    if (load_ready !== 1'b1 || ser_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_idle: ready=%b valid=%b, want 1 0", load_ready, ser_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] w;
    logic [3:0]  pat;
    int          beat;
    int          cyc;
    w    = 16'h8001;
    pat  = 4'b1001;  // ready pattern 1,0,0,1 (bit 3 first)
    beat = 0;
    cyc  = 0;
    load_word(w);
    while (beat < 16 && cyc < 100) begin
      ser_ready = pat[3 - (cyc % 4)];
      n_cmp++;
      if (ser_valid !== 1'b1 || mux_sel !== beat[3:0] || ser_bit !== w[beat]) begin
        n_bad++;
        $display("FAIL bp_cycle%0d: valid=%b sel=%0d bit=%b, want 1 %0d %b", cyc, ser_valid,
                 mux_sel, ser_bit, beat, w[beat]);
      end
      if (ser_ready) beat++;
      cyc++;
      tick();
    end
    n_cmp++;
    if (beat != 16) begin
      n_bad++;
      $display("FAIL bp_timeout: beats=%0d, want 16", beat);
    end
`ifdef SERIALIZER_PARITY_EN
    ser_ready = 1'b0;
    tick();
    n_cmp++;
    if (ser_valid !== 1'b1 || ser_bit !== 1'b0 || ser_last !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_parity_hold: valid=%b bit=%b last=%b, want 1 0 1", ser_valid, ser_bit,
               ser_last);
    end
    ser_ready = 1'b1;
    tick();
`endif
    ser_ready = 1'b1;
    n_cmp++;
    if (load_ready !== 1'b1 || ser_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_idle: ready=%b valid=%b, want 1 0", load_ready, ser_valid);
    end
  endtask

  task automatic test_busy_load();
    ser_ready = 1'b1;
    load_word(16'h0000);
    din        = 16'hFFFF;
    load_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (ser_valid !== 1'b1 || ser_bit !== 1'b0 || mux_data !== 16'h0000) begin
        n_bad++;
        $display("FAIL busy_beat%0d: valid=%b bit=%b data=%h, want 1 0 0000", k, ser_valid,
                 ser_bit, mux_data);
      end
      tick();
    end
`ifdef SERIALIZER_PARITY_EN
    tick();
`endif
    n_cmp++;
    if (load_ready !== 1'b1 || mux_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL busy_idle: ready=%b data=%h, want 1 0000", load_ready, mux_data);
    end
    tick();
    load_valid = 1'b0;
    n_cmp++;
    if (mux_data !== 16'hFFFF || ser_valid !== 1'b1 || ser_bit !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_accept: data=%h valid=%b bit=%b, want FFFF 1 1", mux_data, ser_valid,
               ser_bit);
    end
    for (int k = 0; k < 16 + int'(ParEn); k++) tick();
    n_cmp++;
    if (load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_drain: ready=%b, want 1", load_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_last;
    saw_last  = 1'b0;
    ser_ready = 1'b1;
    load_word(16'h1234);
    for (int k = 0; k < 6; k++) begin
      saw_last = saw_last | ser_last;
      tick();
    end
    rst        = 1'b1;
    load_valid = 1'b1;
    din        = 16'hBEEF;
    tick();
    rst        = 1'b0;
    load_valid = 1'b0;
    n_cmp++;
    if (ser_valid !== 1'b0 || mux_sel !== 4'h0 || load_ready !== 1'b1 || mux_data !== 16'h0) begin
      n_bad++;
      $display("FAIL rstmid_state: valid=%b sel=%h ready=%b data=%h, want 0 0 1 0000", ser_valid,
               mux_sel, load_ready, mux_data);
    end
    for (int k = 0; k < 3; k++) begin
      saw_last = saw_last | ser_last | ser_valid;
      tick();
    end
    n_cmp++;
    if (saw_last !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_last: saw last/valid=%b, want 0", saw_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    int          beats;
    beats     = 0;
    ser_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 16'h00FF : 16'hFF00;
      if (n == 1) begin
        n_cmp++;
        if (ser_valid !== 1'b0 || load_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_gap: valid=%b ready=%b, want 0 1", ser_valid, load_ready);
        end
      end
      load_word(w);
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (ser_valid !== 1'b1 || ser_bit !== w[k]) begin
          n_bad++;
          $display("FAIL b2b_w%0d_beat%0d: valid=%b bit=%b, want 1 %b", n, k, ser_valid, ser_bit,
                   w[k]);
        end
        if (ser_valid === 1'b1) beats++;
        tick();
      end
`ifdef SERIALIZER_PARITY_EN
      tick();
`endif
    end
    n_cmp++;
    if (beats != 32 || ser_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_total: beats=%0d valid=%b, want 32 0", beats, ser_valid);
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    logic [15:0] w;
    logic        p;
    ser_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      w = (n == 0) ? 16'h0007 : 16'h0003;
      p = (n == 0) ? 1'b1 : 1'b0;
      load_word(w);
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (ser_valid !== 1'b1 || ser_bit !== w[k] || ser_last !== 1'b0) begin
          n_bad++;
          $display("FAIL par_w%0d_beat%0d: valid=%b bit=%b last=%b, want 1 %b 0", n, k,
                   ser_valid, ser_bit, ser_last, w[k]);
        end
        tick();
      end
      n_cmp++;
      if (ser_valid !== 1'b1 || ser_bit !== p || ser_last !== 1'b1) begin
        n_bad++;
        $display("FAIL par_w%0d_parity: valid=%b bit=%b last=%b, want 1 %b 1", n, ser_valid,
                 ser_bit, ser_last, p);
      end
      tick();
      n_cmp++;
      if (ser_valid !== 1'b0 || load_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL par_w%0d_idle: valid=%b ready=%b, want 0 1", n, ser_valid, load_ready);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_load();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
